// File: rtl/seg7_priority_decoder.sv
// Recovers the 3-bit index and one-hot line from an active-low 7-segment pattern.
// Patterns are glitch-filtered and delivered once per stable pattern over valid/ready.
module seg7_priority_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] out_onehot,
    output logic       err_illegal,
    output logic [7:0] err_count
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Returns {legal, code}; bits are a..g from MSB to LSB, active-low.
    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        logic [3:0] res;
        case (seg)
            7'b0000001: res = {1'b1, 3'd0};
            7'b1001111: res = {1'b1, 3'd1};
            7'b0010010: res = {1'b1, 3'd2};
            7'b0000110: res = {1'b1, 3'd3};
            7'b1001100: res = {1'b1, 3'd4};
            7'b0100100: res = {1'b1, 3'd5};
            7'b0100000: res = {1'b1, 3'd6};
            7'b0001111: res = {1'b1, 3'd7};
            default:    res = {1'b0, 3'd0};
        endcase
        return res;
    endfunction

    logic [6:0] seg_q_r;
    logic [7:0] run_r;
    state_t     state_r;
    logic       out_valid_r;
    logic [2:0] out_code_r;
    logic [7:0] out_onehot_r;
    logic       err_illegal_r;
    logic [7:0] err_count_r;

    logic [7:0] run_next_s;
    logic       qualify_s;
    logic [3:0] dec_s;
    logic       legal_q_s;
    logic       illegal_q_s;

    // Run-length of the sampled pattern and the single-shot qualify strobe.
    always_comb begin
        run_next_s  = STABLE_MAX;
        qualify_s   = 1'b0;
        dec_s       = decode_seg(seg_q_r);
        legal_q_s   = 1'b0;
        illegal_q_s = 1'b0;
        if (seg_in != seg_q_r) begin
            run_next_s = 8'd1;
        end else if (run_r < STABLE_MAX) begin
            run_next_s = run_r + 8'd1;
        end else begin
            run_next_s = STABLE_MAX;
        end
        qualify_s = (run_next_s == STABLE_MAX) && (run_r != STABLE_MAX);
        if (qualify_s) begin
            legal_q_s   = dec_s[3];
            illegal_q_s = !dec_s[3] && (seg_q_r != SEG_BLANK);
        end else begin
            legal_q_s   = 1'b0;
            illegal_q_s = 1'b0;
        end
    end

    // Input register and run counter; blank counts as already qualified out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q_r <= SEG_BLANK;
            run_r   <= STABLE_MAX;
        end else begin
            seg_q_r <= seg_in;
            run_r   <= run_next_s;
        end
    end

    // Delivery FSM with registered handshake outputs and illegal-pattern accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            out_valid_r   <= 1'b0;
            out_code_r    <= 3'd0;
            out_onehot_r  <= 8'd0;
            err_illegal_r <= 1'b0;
            err_count_r   <= 8'd0;
        end else begin
            err_illegal_r <= illegal_q_s;
            if (illegal_q_s && (err_count_r != 8'd255)) begin
                err_count_r <= err_count_r + 8'd1;
            end
            case (state_r)
                IDLE: begin
                    if (legal_q_s) begin
                        state_r      <= PRESENT;
                        out_valid_r  <= 1'b1;
                        out_code_r   <= dec_s[2:0];
                        out_onehot_r <= 8'd1 << dec_s[2:0];
                    end
                end
                PRESENT: begin
                    // A legal digit arriving while blocked is dropped; on acceptance it reloads.
                    if (out_ready) begin
                        if (legal_q_s) begin
                            out_code_r   <= dec_s[2:0];
                            out_onehot_r <= 8'd1 << dec_s[2:0];
                        end else begin
                            state_r      <= IDLE;
                            out_valid_r  <= 1'b0;
                            out_onehot_r <= 8'd0;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    out_valid_r  <= 1'b0;
                    out_onehot_r <= 8'd0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_r;
    assign out_code    = out_code_r;
    assign out_onehot  = out_onehot_r;
    assign err_illegal = err_illegal_r;
    assign err_count   = err_count_r;

endmodule

// File: doc/seg7_priority_decoder.md
# seg7_priority_decoder

Receive-side counterpart of the priority-encoder / 7-segment driver. It samples an active-low 7-segment pattern, filters glitches with a stability counter, and maps each of the eight legal digit patterns back to its 3-bit code and one-hot 8-bit line. Each result is delivered exactly once per stable pattern over a valid/ready handshake, and illegal patterns are flagged and counted. It sits between a segment bus (pins or loopback) and downstream logic that consumes the recovered input index.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples needed to qualify a pattern. Legal range 2..255; the run counter is 8 bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- seg_in  in  7  active-low segments. bit6=a … bit0=g.
- out_ready  in  1  consumer accepts the result when high with out_valid.
- out_valid  out  1  result available.
- out_code  out  3  recovered index 0..7.
- out_onehot  out  8  1<<out_code while out_valid, else 0.
- err_illegal  out  1  one-cycle pulse when an illegal pattern qualifies.
- err_count  out  8  count of illegal qualifications, saturating at 255.

## Operation
- Legal patterns: 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7.
- Blank: 1111111. Every other value is illegal.
- Input stage: seg_in is registered into seg_q every cycle.
- Run counter:
  - If the next seg_q differs from the current seg_q, run←1.
  - Otherwise run←min(run+1, STABLE_CYCLES).
  - qualify is high on the edge where run becomes STABLE_CYCLES. It fires once per stable pattern.
- FSM states: IDLE, PRESENT.
  - IDLE, qualify with legal digit: load out_code, go to PRESENT.
  - IDLE, qualify with blank: no action.
  - IDLE, qualify with illegal pattern: pulse err_illegal, increment err_count, stay in IDLE.
  - PRESENT: out_valid=1; out_code and out_onehot are held stable.
  - PRESENT, out_valid&&out_ready: transfer completes. Next state is IDLE unless a legal qualify occurs on the same edge (see below).
  - PRESENT, qualify with legal digit and no transfer that edge: new digit dropped, old result held.
  - PRESENT, qualify with illegal pattern: counted and pulsed exactly as in IDLE.
  - Transfer on the same edge as a legal qualify: the new digit is loaded and the FSM stays in PRESENT, so out_valid remains high.
- Re-delivery: the same digit is delivered again only after seg_q has changed (e.g. a blank gap) and then re-qualified.
- err_count holds at 255; err_illegal still pulses when saturated.

## Timing
- Reset values (asynchronous, no clock required):
  - seg_q=1111111, run=STABLE_CYCLES (blank treated as already qualified), FSM=IDLE.
  - out_valid=0, out_code=0, out_onehot=0, err_illegal=0, err_count=0.
- Latency: seg_in steady before edge E is captured into seg_q at E, with run=1. qualify occurs at E+STABLE_CYCLES−1, and out_valid is high after that edge.
  - For STABLE_CYCLES=4: out_valid is high after the 4th edge counted from E.
- Handshake:
  - out_valid, once high, stays high with constant data until accepted.
  - out_ready may be high while out_valid is low; it has no effect then.
  - out_valid falls the edge after acceptance unless a legal reload occurs on the acceptance edge.
- Glitch rejection: a pattern held for fewer than STABLE_CYCLES samples never qualifies.
- err_illegal is high for exactly one cycle, coincident with the err_count increment.
- Reset asserted mid-PRESENT: the pending result is discarded and outputs take their reset values immediately. No delivery follows until a fresh qualification after reset release.

## Test plan
1. Reset, then seg_in=1111111 for 50 cycles → out_valid, err_illegal, out_onehot and err_count all stay 0.
2. STABLE_CYCLES=4, out_ready=1, seg_in=0100000 held → out_valid high after the 4th edge from capture with out_code=6, out_onehot=0x40. It is high for one cycle and never reasserts while the pattern is held. Blank then 0100000 again → delivered a second time.
3. Glitch: seg_in=0000110 for 3 cycles, then 1001111 held → exactly one delivery, out_code=1, out_onehot=0x02. Code 3 is never seen.
4. seg_in=1111110 held → one err_illegal pulse, err_count=1, no out_valid. Alternate 1111110 and 1111101 (4 cycles each) 300 times → err_count=255 and stays 255; pulses continue.
5. Backpressure, out_ready=0:
   - Deliver 2 (0010010) → out_code=2 held.
   - Qualify 5 (0100100) → dropped; out_code stays 2.
   - Hold 7 (0001111) and raise out_ready exactly on its qualify edge → 2 transfers, out_valid stays high with out_code=7 and out_onehot=0x80. Next accepted edge → out_valid falls.
6. Reset mid-PRESENT: with out_valid=1 and out_code=4, assert rst between clock edges → all outputs 0 immediately. After release with seg_in=1001100 still held → run restarts from 1 and 4 is re-delivered after STABLE_CYCLES samples.
